// File: rtl/karatsuba_combine.sv
`default_nettype none
// ============================================================================
//  karatsuba_combine : 3-stage recombination S = z2<<W + (zm-z2-z0)<<W/2 + z0
//  Revision: 1.0
// ============================================================================
module karatsuba_combine #(
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_W-1:0]     z2,
    input  logic [DATA_W-1:0]     z0,
    input  logic [DATA_W+1:0]     zm,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [2*DATA_W-1:0]   S,
    output logic                  out_err
);

    localparam int c_H = DATA_W / 2;

    // Stage 1
    logic                s1_v_q;
    logic [DATA_W-1:0]   s1_z2_q, s1_z0_q;
    logic [DATA_W+1:0]   s1_zm_q;
    logic [DATA_W:0]     s1_sum_q, s1_sum_d;
    // Stage 2
    logic                s2_v_q;
    logic [DATA_W-1:0]   s2_z2_q, s2_z0_q;
    logic [DATA_W+1:0]   s2_mid_q, s2_mid_d;
    logic                s2_err_q, s2_err_d;
    // Stage 3 (output register)
    logic                s3_v_q;
    logic [2*DATA_W-1:0] s3_s_q, s3_s_d;
    logic                s3_err_q;

    logic                w_adv1, w_adv2, w_adv3;
    logic [2*DATA_W-1:0] w_mid_ext;

    // Each stage may load when it is empty or its successor is loading too,
    // so a full pipeline still shifts (and accepts) while the sink is ready.
    assign w_adv3   = !s3_v_q || out_ready;
    assign w_adv2   = !s2_v_q || w_adv3;
    assign w_adv1   = !s1_v_q || w_adv2;
    assign in_ready = w_adv1;

    assign s1_sum_d  = {1'b0, z2} + {1'b0, z0};
    assign s2_mid_d  = s1_zm_q - {1'b0, s1_sum_q};
    assign s2_err_d  = s1_zm_q < {1'b0, s1_sum_q};
    // mid wraps modulo 2^(DATA_W+2) on inconsistent inputs; the final sum
    // is taken modulo 2^(2*DATA_W) so the error result stays deterministic.
    assign w_mid_ext = {{(DATA_W-2){1'b0}}, s2_mid_q};
    assign s3_s_d    = {s2_z2_q, s2_z0_q} + (w_mid_ext << c_H);

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v_q   <= 1'b0;
            s1_z2_q  <= '0;
            s1_z0_q  <= '0;
            s1_zm_q  <= '0;
            s1_sum_q <= '0;
            s2_v_q   <= 1'b0;
            s2_z2_q  <= '0;
            s2_z0_q  <= '0;
            s2_mid_q <= '0;
            s2_err_q <= 1'b0;
            s3_v_q   <= 1'b0;
            s3_s_q   <= '0;
            s3_err_q <= 1'b0;
        end else begin
            if (w_adv1) begin
                s1_v_q <= in_valid;
                if (in_valid) begin
                    s1_z2_q  <= z2;
                    s1_z0_q  <= z0;
                    s1_zm_q  <= zm;
                    s1_sum_q <= s1_sum_d;
                end
            end
            if (w_adv2) begin
                s2_v_q <= s1_v_q;
                if (s1_v_q) begin
                    s2_z2_q  <= s1_z2_q;
                    s2_z0_q  <= s1_z0_q;
                    s2_mid_q <= s2_mid_d;
                    s2_err_q <= s2_err_d;
                end
            end
            // Data only updates on a real result so S holds while empty/stalled.
            if (w_adv3) begin
                s3_v_q <= s2_v_q;
                if (s2_v_q) begin
                    s3_s_q   <= s3_s_d;
                    s3_err_q <= s2_err_q;
                end
            end
        end
    end

    assign out_valid = s3_v_q;
    assign S         = s3_s_q;
    assign out_err   = s3_err_q;

endmodule
`default_nettype wire

// File: doc/karatsuba_combine.md
Name: karatsuba_combine

Overview:
- Downstream recombination stage for the Karatsuba multiplier.
- Consumes the three half-width partial products from the sub-multipliers:
  - z2 = AH*BH
  - z0 = AL*BL
  - zm = (AH+AL)*(BH+BL)
- Produces the full 2*DATA_W-bit product S = z2<<DATA_W + (zm - z2 - z0)<<(DATA_W/2) + z0.
- 3-stage pipeline with valid/ready handshake on both sides and a consistency-error flag.

Parameters:
- DATA_W, 32, operand width of the original multiply; must be even and >= 4. H = DATA_W/2.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  partial-product triple valid
- in_ready  out  1  stage can accept triple this cycle
- z2  in  DATA_W  AH*BH
- z0  in  DATA_W  AL*BL
- zm  in  DATA_W+2  (AH+AL)*(BH+BL)
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- S  out  2*DATA_W  recombined product
- out_err  out  1  zm < z2+z0 detected for this result (inconsistent inputs)

Behaviour:
- Reset (rst=1 at posedge clk): all stage valids cleared; out_valid=0, S=0, out_err=0. in_ready=1 combinationally once valids are clear.
- Reset mid-operation: in-flight results are discarded, with no partial output after reset deasserts.
- Transfers: in on in_valid&&in_ready at posedge; out on out_valid&&out_ready at posedge.
- Stage advance rule: stage k loads when !v_k || adv_{k+1}.
  - adv_3 = !out_valid || out_ready.
  - in_ready = !v1 || adv_2.
  - in_ready must not depend combinationally on in_valid.
- Stage 1: register z2, z0, zm; sum1 = z2 + z0, computed at DATA_W+1 bits, no truncation.
- Stage 2:
  - mid = zm - sum1, computed at DATA_W+2 bits.
  - err2 = (zm < sum1), unsigned compare.
  - Carry z2, z0 forward.
- Stage 3 (output register):
  - S = {z2, z0} + (mid << H), computed modulo 2^(2*DATA_W).
  - out_err = err2.
- When err=1: S is still the modulo result (deterministic), not forced to zero.
- Latency: 3 cycles from input transfer to out_valid with out_ready held 1. Throughput: 1 result/cycle.
- Backpressure:
  - While out_valid && !out_ready, S and out_err hold stable.
  - The pipeline fills behind the stall; in_ready drops only when all 3 stages are full.
  - Zero bubbles are inserted on release.
- Simultaneous full pipeline + out_ready=1 + in_valid=1: all stages shift and the new input is accepted in the same cycle.
- Ordering: results leave in input order; no drops, no duplicates.
- Empty pipeline: out_valid=0; S holds its last value (don't-care for checking).

Test Plan:
- Reset: assert rst 2 cycles with in_valid=1 -> out_valid=0, S=0, out_err=0, and no output appears after release.
- Small operands (DATA_W=32), A=0x00020003, B=0x00040005: drive z2=8, z0=15, zm=45 -> 3 cycles later S=0x00000008_0016000F, out_err=0.
- Max operands, A=B=0xFFFFFFFF: drive z2=z0=0xFFFE0001, zm=0x3_FFF80004 -> S=0xFFFFFFFE_00000001, out_err=0.
- Error: drive z2=1, z0=1, zm=1 -> out_err=1, S = ({1,1} + ((1-2) mod 2^34 << 16)) mod 2^64, deterministic.
- Back-to-back: 20 random valid (A,B) triples on consecutive cycles with out_ready=1 -> 20 consecutive out_valid cycles, each S = A*B, in order.
- Backpressure: hold out_ready=0 for 6 cycles while streaming inputs -> in_ready falls after 3 accepts, S stays stable, and after release all results are correct and in order with no loss.
